// File: rtl/dict_phase_sequencer_pkg.sv
// Shared types and helpers for the dictionary load/lookup phase sequencer.
package dict_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StLookup,
        StDrain
    } dict_phase_t;

    localparam int unsigned DefaultDictSize    = 4096;
    localparam int unsigned DefaultNumElements = 8;

    // Wide enough to hold DICT_SIZE itself, not just DICT_SIZE-1.
    typedef logic [$clog2(DefaultDictSize):0] count_t;

    function automatic int unsigned count_width(input int unsigned dict_size);
        return $clog2(dict_size) + 1;
    endfunction

endpackage

// File: rtl/dict_lane_mask.sv
// Trims a beat's keep mask to the remaining dictionary room, lowest lane first,
// and reports how many lanes survived and whether any were dropped.
module dict_lane_mask
    import dict_phase_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = DefaultNumElements,
    parameter int unsigned COUNT_WIDTH  = 13
) (
    input  logic [NUM_ELEMENTS-1:0] i_keep,
    input  logic [COUNT_WIDTH-1:0]  i_room,
    output logic [NUM_ELEMENTS-1:0] o_keep,
    output logic [COUNT_WIDTH-1:0]  o_popcount,
    output logic                    o_trimmed
);

    logic [COUNT_WIDTH-1:0] w_run;

    // w_run is the prefix popcount of lanes already kept below lane i.
    always_comb begin
        w_run     = '0;
        o_keep    = '0;
        o_trimmed = 1'b0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (i_keep[i]) begin
                if (w_run < i_room) begin
                    o_keep[i] = 1'b1;
                    w_run     = w_run + 1'b1;
                end else begin
                    o_trimmed = 1'b1;
                end
            end
        end
    end

    assign o_popcount = w_run;

endmodule

// File: rtl/dict_phase_sequencer.sv
// Runs the Dictionary load -> lookup -> drain protocol for one column batch,
// counting loaded values and flagging capacity overflow and out-of-range ids.
module dict_phase_sequencer
    import dict_phase_sequencer_pkg::*;
#(
    parameter type         value_t      = logic [31:0],
    parameter type         id_t         = logic [15:0],
    parameter int unsigned NUM_ELEMENTS = DefaultNumElements,
    parameter int unsigned DICT_SIZE    = DefaultDictSize,
    localparam int unsigned CountWidth  = count_width(DICT_SIZE)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,

    input  logic                           i_in_values_valid,
    input  value_t [NUM_ELEMENTS-1:0]      i_in_values_data,
    input  logic   [NUM_ELEMENTS-1:0]      i_in_values_keep,
    input  logic                           i_in_values_last,
    output logic                           o_in_values_ready,

    input  logic                           i_in_ids_valid,
    input  id_t    [NUM_ELEMENTS-1:0]      i_in_ids_data,
    input  logic   [NUM_ELEMENTS-1:0]      i_in_ids_keep,
    input  logic                           i_in_ids_last,
    output logic                           o_in_ids_ready,

    output logic                           o_out_values_valid,
    output value_t [NUM_ELEMENTS-1:0]      o_out_values_data,
    output logic   [NUM_ELEMENTS-1:0]      o_out_values_keep,
    output logic                           o_out_values_last,
    input  logic                           i_out_values_ready,

    output logic                           o_out_ids_valid,
    output id_t    [NUM_ELEMENTS-1:0]      o_out_ids_data,
    output logic   [NUM_ELEMENTS-1:0]      o_out_ids_keep,
    output logic                           o_out_ids_last,
    input  logic                           i_out_ids_ready,

    input  logic                           i_res_done,
    output logic   [CountWidth-1:0]        o_loaded_count,
    output logic                           o_overflow,
    output logic                           o_oob_id,
    output logic                           o_busy
);

    localparam int unsigned IdWidth  = $bits(id_t);
    localparam int unsigned CmpWidth = (IdWidth > CountWidth) ? IdWidth : CountWidth;

    dict_phase_t           r_state;
    logic [CountWidth-1:0] r_count;
    logic                  r_overflow;
    logic                  r_oob;
    logic                  r_started;
    logic                  r_batch_open;

    logic [CountWidth-1:0]   w_room;
    logic [NUM_ELEMENTS-1:0] w_val_keep;
    logic [CountWidth-1:0]   w_val_pop;
    logic                    w_val_trim;
    logic                    w_val_silent;
    logic                    w_in_load;
    logic                    w_in_lookup;
    logic                    w_val_hs;
    logic                    w_id_hs;
    logic                    w_oob;

    assign w_room = CountWidth'(DICT_SIZE) - r_count;

    dict_lane_mask #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .COUNT_WIDTH  (CountWidth)
    ) u_lane_mask (
        .i_keep     (i_in_values_keep),
        .i_room     (w_room),
        .o_keep     (w_val_keep),
        .o_popcount (w_val_pop),
        .o_trimmed  (w_val_trim)
    );

    // A beat emptied by trimming is swallowed unless it closes the batch.
    assign w_val_silent = (w_val_keep == '0) && !i_in_values_last;

    // r_started holds both input readies and output valids low for one cycle after reset.
    assign w_in_load   = r_started && (r_state == StLoad);
    assign w_in_lookup = r_started && (r_state == StLookup);

    assign o_out_values_valid = w_in_load && i_in_values_valid && !w_val_silent;
    assign o_out_values_data  = i_in_values_data;
    assign o_out_values_keep  = w_val_keep;
    assign o_out_values_last  = i_in_values_last;
    assign o_in_values_ready  = w_in_load && (i_out_values_ready || w_val_silent);

    assign o_out_ids_valid = w_in_lookup && i_in_ids_valid;
    assign o_out_ids_data  = i_in_ids_data;
    assign o_out_ids_keep  = i_in_ids_keep;
    assign o_out_ids_last  = i_in_ids_last;
    assign o_in_ids_ready  = w_in_lookup && i_out_ids_ready;

    assign w_val_hs = i_in_values_valid && o_in_values_ready;
    assign w_id_hs  = i_in_ids_valid && o_in_ids_ready;

    always_comb begin
        w_oob = 1'b0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (i_in_ids_keep[i] &&
                (CmpWidth'(i_in_ids_data[i]) >= CmpWidth'(r_count))) begin
                w_oob = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StLoad;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_oob        <= 1'b0;
            r_started    <= 1'b0;
            r_batch_open <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                StLoad: begin
                    if (w_val_hs) begin
                        r_count      <= r_count + w_val_pop;
                        r_batch_open <= 1'b1;
                        // First value beat of a batch restarts the sticky flags.
                        if (r_batch_open) begin
                            r_overflow <= r_overflow | w_val_trim;
                        end else begin
                            r_overflow <= w_val_trim;
                            r_oob      <= 1'b0;
                        end
                        if (i_in_values_last) begin
                            r_state <= StLookup;
                        end
                    end
                end
                StLookup: begin
                    if (w_id_hs) begin
                        if (w_oob) begin
                            r_oob <= 1'b1;
                        end
                        if (i_in_ids_last) begin
                            if (i_res_done) begin
                                r_state      <= StLoad;
                                r_count      <= '0;
                                r_batch_open <= 1'b0;
                            end else begin
                                r_state <= StDrain;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (i_res_done) begin
                        r_state      <= StLoad;
                        r_count      <= '0;
                        r_batch_open <= 1'b0;
                    end
                end
                default: r_state <= StLoad;
            endcase
        end
    end

    assign o_loaded_count = r_count;
    assign o_overflow     = r_overflow;
    assign o_oob_id       = r_oob;
    assign o_busy         = (r_state != StLoad) || (r_count != '0);

endmodule

// File: tb/tb_dict_phase_sequencer.sv
// Directed bench: a large (4096) and a small (16) sequencer share one stimulus stream.
module tb_dict_phase_sequencer;

    localparam int unsigned NE = 8;
    typedef logic [31:0] value_t;
    typedef logic [15:0] id_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic                vals_valid, vals_last, ids_valid, ids_last;
    value_t [NE-1:0]     vals_data;
    id_t    [NE-1:0]     ids_data;
    logic   [NE-1:0]     vals_keep, ids_keep;
    logic                ov_ready, oi_ready, res_done;

    logic                b_vals_ready, b_ids_ready, b_ov_valid, b_ov_last, b_oi_valid, b_oi_last;
    value_t [NE-1:0]     b_ov_data;
    id_t    [NE-1:0]     b_oi_data;
    logic   [NE-1:0]     b_ov_keep, b_oi_keep;
    logic   [12:0]       b_count;
    logic                b_ovf, b_oob, b_busy;

    logic                s_vals_ready, s_ids_ready, s_ov_valid, s_ov_last, s_oi_valid, s_oi_last;
    value_t [NE-1:0]     s_ov_data;
    id_t    [NE-1:0]     s_oi_data;
    logic   [NE-1:0]     s_ov_keep, s_oi_keep;
    logic   [4:0]        s_count;
    logic                s_ovf, s_oob, s_busy;

    dict_phase_sequencer #(
        .value_t (value_t), .id_t (id_t), .NUM_ELEMENTS (NE), .DICT_SIZE (4096)
    ) u_big (
        .i_clk (clk), .i_rst_n (rst_n),
        .i_in_values_valid (vals_valid), .i_in_values_data (vals_data),
        .i_in_values_keep (vals_keep), .i_in_values_last (vals_last),
        .o_in_values_ready (b_vals_ready),
        .i_in_ids_valid (ids_valid), .i_in_ids_data (ids_data),
        .i_in_ids_keep (ids_keep), .i_in_ids_last (ids_last), .o_in_ids_ready (b_ids_ready),
        .o_out_values_valid (b_ov_valid), .o_out_values_data (b_ov_data),
        .o_out_values_keep (b_ov_keep), .o_out_values_last (b_ov_last),
        .i_out_values_ready (ov_ready),
        .o_out_ids_valid (b_oi_valid), .o_out_ids_data (b_oi_data),
        .o_out_ids_keep (b_oi_keep), .o_out_ids_last (b_oi_last), .i_out_ids_ready (oi_ready),
        .i_res_done (res_done), .o_loaded_count (b_count), .o_overflow (b_ovf),
        .o_oob_id (b_oob), .o_busy (b_busy)
    );

    dict_phase_sequencer #(
        .value_t (value_t), .id_t (id_t), .NUM_ELEMENTS (NE), .DICT_SIZE (16)
    ) u_small (
        .i_clk (clk), .i_rst_n (rst_n),
        .i_in_values_valid (vals_valid), .i_in_values_data (vals_data),
        .i_in_values_keep (vals_keep), .i_in_values_last (vals_last),
        .o_in_values_ready (s_vals_ready),
        .i_in_ids_valid (ids_valid), .i_in_ids_data (ids_data),
        .i_in_ids_keep (ids_keep), .i_in_ids_last (ids_last), .o_in_ids_ready (s_ids_ready),
        .o_out_values_valid (s_ov_valid), .o_out_values_data (s_ov_data),
        .o_out_values_keep (s_ov_keep), .o_out_values_last (s_ov_last),
        .i_out_values_ready (ov_ready),
        .o_out_ids_valid (s_oi_valid), .o_out_ids_data (s_oi_data),
        .o_out_ids_keep (s_oi_keep), .o_out_ids_last (s_oi_last), .i_out_ids_ready (oi_ready),
        .i_res_done (res_done), .o_loaded_count (s_count), .o_overflow (s_ovf),
        .o_oob_id (s_oob), .o_busy (s_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input value_t base, input logic [NE-1:0] keep, input logic last);
        vals_valid = 1'b1;
        for (int i = 0; i < NE; i++) vals_data[i] = base + 32'(i);
        vals_keep = keep;
        vals_last = last;
    endtask

    task automatic set_ids(input id_t base, input logic [NE-1:0] keep, input logic last);
        ids_valid = 1'b1;
        for (int i = 0; i < NE; i++) ids_data[i] = base + 16'(i);
        ids_keep = keep;
        ids_last = last;
    endtask

    task automatic check_vals(input string tag, input value_t base);
        for (int i = 0; i < NE; i++) begin
            check_eq($sformatf("%s_lane%0d", tag, i), b_ov_data[i], base + 32'(i));
        end
    endtask

    initial begin
        vals_valid = 0; vals_last = 0; vals_keep = '0; vals_data = '0;
        ids_valid = 0; ids_last = 0; ids_keep = '0; ids_data = '0;
        ov_ready = 1; oi_ready = 1; res_done = 0;
        #1 rst_n = 1'b0;
        repeat (3) tick();

        check_eq("rst_count", b_count, 0);
        check_eq("rst_overflow", b_ovf, 0);
        check_eq("rst_oob", b_oob, 0);
        check_eq("rst_busy", b_busy, 0);
        check_eq("rst_ov_valid", b_ov_valid, 0);
        check_eq("rst_oi_valid", b_oi_valid, 0);

        // Release: first cycle keeps the value input stalled.
        rst_n = 1'b1;
        set_vals(32'h1000, 8'hFF, 1'b0);
        set_ids(16'd0, 8'hFF, 1'b0);
        #1;
        check_eq("init_vals_ready", b_vals_ready, 0);
        check_eq("init_ov_valid", b_ov_valid, 0);
        tick();
        check_eq("t1_vals_ready", b_vals_ready, 1);
        check_eq("t1_ov_valid", b_ov_valid, 1);
        check_eq("t1_ov_keep", b_ov_keep, 8'hFF);
        check_vals("t1_beat0", 32'h1000);
        check_eq("t2_ids_ready_in_load", b_ids_ready, 0);
        check_eq("t2_oi_valid_in_load", b_oi_valid, 0);
        tick();
        check_eq("t1_count8", b_count, 8);

        set_vals(32'h2000, 8'hFF, 1'b0);
        #1;
        check_vals("t1_beat1", 32'h2000);
        tick();
        check_eq("t1_count16", b_count, 16);
        check_eq("t3_small_count16", s_count, 16);
        check_eq("t3_small_ovf_beat1", s_ovf, 0);

        set_vals(32'h3000, 8'hFF, 1'b1);
        #1;
        check_vals("t1_beat2", 32'h3000);
        check_eq("t2_ids_ready_at_last", b_ids_ready, 0);
        check_eq("t3_small_last_keep", s_ov_keep, 8'h00);
        check_eq("t3_small_last_valid", s_ov_valid, 1);
        check_eq("t3_small_last_ready", s_vals_ready, 1);
        tick();
        check_eq("t1_count24", b_count, 24);
        check_eq("t3_small_count_sat", s_count, 16);
        check_eq("t3_small_overflow", s_ovf, 1);
        check_eq("t1_big_no_overflow", b_ovf, 0);
        check_eq("t1_busy_lookup", b_busy, 1);

        vals_valid = 1'b0;
        #1;
        check_eq("t2_ids_ready", b_ids_ready, 1);
        check_eq("t2_oi_valid", b_oi_valid, 1);
        check_eq("t2_oi_lane5", b_oi_data[5], 5);
        tick();
        check_eq("t4_oob_none", b_oob, 0);

        // Kept ids 3 and 20; unkept lane 2 carries 30 and must be ignored.
        set_ids(16'd0, 8'h03, 1'b0);
        ids_data[0] = 16'd3; ids_data[1] = 16'd20; ids_data[2] = 16'd30;
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
        check_eq("t4_big_oob_unkept", b_oob, 0);
        check_eq("t4_small_oob", s_oob, 1);
        check_eq("rd_ignored_in_lookup", b_ids_ready, 1);

        // Empty id batch closes lookup; new values offered must stall.
        set_ids(16'd0, 8'h00, 1'b1);
        set_vals(32'h4000, 8'hFF, 1'b0);
        #1;
        check_eq("t5_empty_ids_valid", b_oi_valid, 1);
        check_eq("t5_empty_ids_last", b_oi_last, 1);
        check_eq("t5_vals_ready_lookup", b_vals_ready, 0);
        tick();
        ids_valid = 1'b0;
        check_eq("t5_drain_vals_ready", b_vals_ready, 0);
        check_eq("t5_drain_ov_valid", b_ov_valid, 0);
        check_eq("t5_drain_ids_ready", b_ids_ready, 0);
        check_eq("t5_drain_busy", b_busy, 1);
        tick();
        check_eq("t5_drain_hold", b_vals_ready, 0);
        check_eq("t5_drain_count", b_count, 24);
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
        check_eq("t5_count0", b_count, 0);
        check_eq("t5_vals_ready_load", b_vals_ready, 1);
        check_eq("t5_busy_idle", b_busy, 0);
        check_eq("t5_small_ovf_sticky", s_ovf, 1);
        check_eq("t5_small_oob_sticky", s_oob, 1);

        // Ten values, then ids {3,9,10} with res_done in the same cycle as the id last.
        tick();
        check_eq("t4_count8", b_count, 8);
        check_eq("sticky_clear_ovf", s_ovf, 0);
        check_eq("sticky_clear_oob", s_oob, 0);
        set_vals(32'h5000, 8'h03, 1'b1);
        tick();
        check_eq("t4_count10", b_count, 10);
        vals_valid = 1'b0;
        set_ids(16'd0, 8'h07, 1'b1);
        ids_data[0] = 16'd3; ids_data[1] = 16'd9; ids_data[2] = 16'd10;
        res_done = 1'b1;
        #1;
        check_eq("t4_oi_valid", b_oi_valid, 1);
        check_eq("t4_oi_keep", b_oi_keep, 8'h07);
        check_eq("t4_oi_lane2", b_oi_data[2], 10);
        tick();
        res_done = 1'b0;
        ids_valid = 1'b0;
        check_eq("t4_oob", b_oob, 1);
        check_eq("rd_same_cycle_count", b_count, 0);
        check_eq("rd_same_cycle_busy", b_busy, 0);

        // Small instance: partial trim of a sparse mask, then a silent drop.
        set_vals(32'h6000, 8'hFF, 1'b0);
        tick();
        check_eq("t3_big_oob_cleared", b_oob, 0);
        set_vals(32'h7000, 8'hF0, 1'b0);
        tick();
        check_eq("t3_small_count12", s_count, 12);
        set_vals(32'h8000, 8'hAB, 1'b0);
        #1;
        check_eq("t3_small_trim_keep", s_ov_keep, 8'h2B);
        check_eq("t3_big_keep", b_ov_keep, 8'hAB);
        tick();
        check_eq("t3_small_count_full", s_count, 16);
        check_eq("t3_small_ovf_trim", s_ovf, 1);
        check_eq("t3_big_count17", b_count, 17);
        set_vals(32'h9000, 8'hFF, 1'b0);
        #1;
        check_eq("t3_drop_valid", s_ov_valid, 0);
        check_eq("t3_drop_ready", s_vals_ready, 1);
        check_eq("t3_big_forward", b_ov_valid, 1);
        tick();
        check_eq("t3_big_count25", b_count, 25);
        check_eq("t3_small_count_held", s_count, 16);
        set_vals(32'hA000, 8'h01, 1'b1);
        #1;
        check_eq("t3_last_valid", s_ov_valid, 1);
        check_eq("t3_last_keep", s_ov_keep, 8'h00);
        tick();
        vals_valid = 1'b0;
        check_eq("t3_big_count26", b_count, 26);

        // Reset in the middle of lookup.
        set_ids(16'd0, 8'hFF, 1'b0);
        #1;
        check_eq("t6_ids_ready_pre", b_ids_ready, 1);
        rst_n = 1'b0;
        tick();
        check_eq("t6_count", b_count, 0);
        check_eq("t6_small_ovf", s_ovf, 0);
        check_eq("t6_busy", b_busy, 0);
        check_eq("t6_ids_ready", b_ids_ready, 0);
        check_eq("t6_oi_valid", b_oi_valid, 0);
        ids_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Empty value batch -> lookup with count 0; any kept id is out of range.
        set_vals(32'hB000, 8'h00, 1'b1);
        #1;
        check_eq("t6_empty_vals_valid", b_ov_valid, 1);
        tick();
        vals_valid = 1'b0;
        check_eq("t6_empty_count", b_count, 0);
        check_eq("t6_empty_lookup", b_ids_ready, 1);
        check_eq("t6_empty_busy", b_busy, 1);
        set_ids(16'd0, 8'h01, 1'b1);
        tick();
        ids_valid = 1'b0;
        check_eq("t6_empty_oob", b_oob, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
